forward_pass: RTL and testbench

FORWARD_PASS -- requirements
Module: forward_pass

---
 rtl/nn_pkg.sv | 27 ++
 rtl/nn_mac.sv | 33 +++
 rtl/forward_pass.sv | 180 ++++++++++++++++++
 tb/tb_forward_pass.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Widths, defaults and FSM state encoding shared by the
//                forward-pass and backprop stages of the small network.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    localparam int NUM_HIDDEN_DEF = 4;   // default hidden neuron count
    localparam int X_W            = 4;   // sample input width
    localparam int W_W            = 8;   // weight width
    localparam int H_W            = 10;  // saturated hidden activation width
    localparam int P_W            = H_W + W_W; // full MAC product width
    localparam int F_W            = 23;  // network output / accumulator width

    // Forward-pass sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HIDDEN  = 3'd1,
        OUTPUT  = 3'd2,
        DONE    = 3'd3,
        WAIT_BP = 3'd4
    } fsm_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_mac.sv
`default_nettype none
// ============================================================================
//  Module      : nn_mac
//  Description : Unsigned H_W x W_W multiplier. With i_sat set the product is
//                clamped to the largest H_W-bit value, producing a hidden
//                activation; with i_sat clear the full product is returned.
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_mac
    import nn_pkg::*;
(
    input  logic [H_W-1:0] i_a,
    input  logic [W_W-1:0] i_b,
    input  logic           i_sat,
    output logic [P_W-1:0] o_p
);

    localparam logic [P_W-1:0] c_sat_max = P_W'((1 << H_W) - 1);

    logic [P_W-1:0] w_full;

    assign w_full = P_W'(i_a) * P_W'(i_b);

    // Clamp to the activation range only in saturate mode
    always_comb begin
        o_p = w_full;
        if (i_sat && (w_full > c_sat_max)) begin
            o_p = c_sat_max;
        end
    end

endmodule : nn_mac
`default_nettype wire

// File: rtl/forward_pass.sv
`default_nettype none
// ============================================================================
//  Module      : forward_pass
//  Description : Sequential forward pass of a 1-input, NUM_HIDDEN-hidden,
//                1-output network. One neuron per cycle through a shared MAC:
//                hidden activations first (saturated), then the output
//                accumulation. Hands off to the backprop stage with a level
//                enable held until acknowledged.
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_pass
    import nn_pkg::*;
#(
    parameter int NUM_HIDDEN = NUM_HIDDEN_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [X_W-1:0]            x_i,
    input  logic [NUM_HIDDEN*W_W-1:0] w_hidden_i,
    input  logic [NUM_HIDDEN*W_W-1:0] w_out_i,
    input  logic                      b_end_i,
    output logic [NUM_HIDDEN*H_W-1:0] hidden_val_o,
    output logic [F_W-1:0]            final_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      b_pass_o
);

    localparam int c_idx_w = $clog2(NUM_HIDDEN) + 1;
    localparam int c_sel_w = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_HIDDEN - 1);

    fsm_state_t       r_state;
    fsm_state_t       w_state_next;

    logic [c_idx_w-1:0] r_idx;
    logic [c_sel_w-1:0] w_sel;
    logic               w_idx_last;

    logic [X_W-1:0]   r_x;
    logic [W_W-1:0]   r_w_hidden [NUM_HIDDEN];
    logic [W_W-1:0]   r_w_out    [NUM_HIDDEN];
    logic [H_W-1:0]   r_hidden   [NUM_HIDDEN];
    logic [F_W-1:0]   r_acc;
    logic [F_W-1:0]   r_final;
    logic             r_done;
    logic             r_b_pass;

    logic [H_W-1:0]   w_mac_a;
    logic [W_W-1:0]   w_mac_b;
    logic             w_mac_sat;
    logic [P_W-1:0]   w_mac_p;

    // idx never exceeds NUM_HIDDEN-1, so its low bits address the neuron arrays
    assign w_sel      = r_idx[c_sel_w-1:0];
    assign w_idx_last = (r_idx == c_last_idx);

    // State register; soft clear behaves like reset but on the clock edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else if (clear_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start and acknowledge only matter in their own states
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_i)    w_state_next = HIDDEN;
            HIDDEN:  if (w_idx_last) w_state_next = OUTPUT;
            OUTPUT:  if (w_idx_last) w_state_next = DONE;
            DONE:                    w_state_next = WAIT_BP;
            WAIT_BP: if (b_end_i)    w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    // MAC operand select: x*w_hidden saturated in HIDDEN, hidden*w_out otherwise
    always_comb begin
        w_mac_a   = {{(H_W - X_W){1'b0}}, r_x};
        w_mac_b   = r_w_hidden[w_sel];
        w_mac_sat = 1'b1;
        if (r_state == OUTPUT) begin
            w_mac_a   = r_hidden[w_sel];
            w_mac_b   = r_w_out[w_sel];
            w_mac_sat = 1'b0;
        end
    end

    nn_mac u_mac (
        .i_a   (w_mac_a),
        .i_b   (w_mac_b),
        .i_sat (w_mac_sat),
        .o_p   (w_mac_p)
    );

    // Datapath: operand latch, per-neuron writes, accumulation and hand-off flags
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idx    <= '0;
            r_x      <= '0;
            r_acc    <= '0;
            r_final  <= '0;
            r_done   <= 1'b0;
            r_b_pass <= 1'b0;
            for (int j = 0; j < NUM_HIDDEN; j++) begin
                r_w_hidden[j] <= '0;
                r_w_out[j]    <= '0;
                r_hidden[j]   <= '0;
            end
        end else if (clear_i) begin
            r_idx    <= '0;
            r_x      <= '0;
            r_acc    <= '0;
            r_final  <= '0;
            r_done   <= 1'b0;
            r_b_pass <= 1'b0;
            for (int j = 0; j < NUM_HIDDEN; j++) begin
                r_w_hidden[j] <= '0;
                r_w_out[j]    <= '0;
                r_hidden[j]   <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_x   <= x_i;
                        r_idx <= '0;
                        r_acc <= '0;
                        for (int j = 0; j < NUM_HIDDEN; j++) begin
                            r_w_hidden[j] <= w_hidden_i[j*W_W +: W_W];
                            r_w_out[j]    <= w_out_i[j*W_W +: W_W];
                        end
                    end
                end
                HIDDEN: begin
                    r_hidden[w_sel] <= w_mac_p[H_W-1:0];
                    r_idx           <= w_idx_last ? '0 : r_idx + 1'b1;
                end
                OUTPUT: begin
                    r_acc <= r_acc + F_W'(w_mac_p);
                    r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end
                DONE: begin
                    r_final  <= r_acc;
                    r_done   <= 1'b1;
                    r_b_pass <= 1'b1;
                end
                WAIT_BP: begin
                    if (b_end_i) begin
                        r_b_pass <= 1'b0;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_HIDDEN; g++) begin : g_pack
            assign hidden_val_o[g*H_W +: H_W] = r_hidden[g];
        end
    endgenerate

    assign final_o  = r_final;
    assign busy_o   = (r_state != IDLE);
    assign done_o   = r_done;
    assign b_pass_o = r_b_pass;

endmodule : forward_pass
`default_nettype wire

// File: tb/tb_forward_pass.sv
`default_nettype none
// ============================================================================
//  Module      : tb_forward_pass
//  Description : Self-checking bench for forward_pass against an arithmetic
//                reference model of the network (saturated products, sum).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_pass;

    localparam int NH  = 4;
    localparam int LAT = 2 * NH + 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              start_i = 1'b0;
    logic [3:0]        x_i = '0;
    logic [NH*8-1:0]   w_hidden_i = '0;
    logic [NH*8-1:0]   w_out_i = '0;
    logic              b_end_i = 1'b0;
    logic [NH*10-1:0]  hidden_val_o;
    logic [22:0]       final_o;
    logic              busy_o;
    logic              done_o;
    logic              b_pass_o;

    int n_chk  = 0;
    int n_fail = 0;

    forward_pass #(.NUM_HIDDEN(NH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .start_i      (start_i),
        .x_i          (x_i),
        .w_hidden_i   (w_hidden_i),
        .w_out_i      (w_out_i),
        .b_end_i      (b_end_i),
        .hidden_val_o (hidden_val_o),
        .final_o      (final_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .b_pass_o     (b_pass_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference network: hidden = min(x*wh, 1023); out = sum(hidden*wo)
    function automatic void model(input logic [3:0] x, input logic [NH*8-1:0] wh,
                                  input logic [NH*8-1:0] wo,
                                  output logic [NH*10-1:0] hv, output logic [22:0] fin);
        int s;
        int p;
        s = 0;
        for (int j = 0; j < NH; j++) begin
            p = int'(x) * int'(wh[j*8 +: 8]);
            if (p > 1023) p = 1023;
            hv[j*10 +: 10] = p[9:0];
            s = s + p * int'(wo[j*8 +: 8]);
        end
        fin = s[22:0];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [3:0] x, input logic [NH*8-1:0] wh, input logic [NH*8-1:0] wo);
        x_i = x; w_hidden_i = wh; w_out_i = wo; start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Edges after the start edge until done_o is seen; bounded
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_o === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (done_o === 1'b1) cnt++;
        end
    endtask

    task automatic ack();
        b_end_i = 1'b1;
        tick();
        b_end_i = 1'b0;
    endtask

    function automatic logic [NH*8-1:0] fill8(input logic [7:0] v);
        logic [NH*8-1:0] r;
        for (int j = 0; j < NH; j++) r[j*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [NH*8-1:0] rnd8();
        logic [NH*8-1:0] r;
        for (int j = 0; j < NH; j++) r[j*8 +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    initial begin
        logic [NH*10-1:0] ehv, ehv1, emix;
        logic [22:0]      efin, fin_snap;
        logic [NH*8-1:0]  wh, wo;
        logic [3:0]       x;
        int               lat, cnt;
        logic             stable;

        // ---- reset state ----
        #12;
        chk("rst_hidden", 64'(hidden_val_o), 0);
        chk("rst_final",  64'(final_o), 0);
        chk("rst_busy",   64'(busy_o), 0);
        chk("rst_flags",  64'({done_o, b_pass_o}), 0);
        @(posedge clk_i); #1 rst_i = 1'b1;
        tick();

        // ---- basic pass ----
        do_start(4'd3, fill8(8'd10), fill8(8'd2));
        chk("basic_busy", 64'(busy_o), 1);
        wait_done(lat);
        chk("basic_latency", 64'(lat), 64'(LAT));
        chk("basic_hidden",  64'(hidden_val_o), 64'({NH{10'd30}}));
        chk("basic_final",   64'(final_o), 240);
        chk("basic_bpass",   64'(b_pass_o), 1);
        tick();
        chk("basic_done_pulse", 64'(done_o), 0);

        // ---- handshake hold ----
        fin_snap = final_o;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (b_pass_o !== 1'b1 || final_o !== fin_snap || busy_o !== 1'b1 ||
                hidden_val_o !== {NH{10'd30}}) stable = 1'b0;
        end
        chk("wait_stable", 64'(stable), 1);
        ack();
        chk("ack_busy",  64'(busy_o), 0);
        chk("ack_bpass", 64'(b_pass_o), 0);
        chk("ack_final_hold", 64'(final_o), 240);

        // ---- saturation ----
        do_start(4'd15, fill8(8'd255), fill8(8'd255));
        wait_done(lat);
        chk("sat_latency", 64'(lat), 64'(LAT));
        chk("sat_hidden",  64'(hidden_val_o), 64'({NH{10'd1023}}));
        chk("sat_final",   64'(final_o), 64'(1043460));
        ack();

        // ---- ignore start in HIDDEN, start+b_end in WAIT_BP ----
        x = 4'($urandom_range(1, 15)); wh = rnd8(); wo = rnd8();
        model(x, wh, wo, ehv, efin);
        do_start(x, wh, wo);
        x_i = ~x; w_hidden_i = rnd8(); w_out_i = rnd8(); start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(lat);
        chk("ign_latency", 64'(lat), 64'(LAT - 1));
        chk("ign_hidden",  64'(hidden_val_o), 64'(ehv));
        chk("ign_final",   64'(final_o), 64'(efin));
        start_i = 1'b1; b_end_i = 1'b1;
        tick();
        start_i = 1'b0; b_end_i = 1'b0;
        chk("both_busy", 64'(busy_o), 0);
        count_done(12, cnt);
        chk("both_no_pass", 64'({cnt[7:0], busy_o}), 0);

        // ---- random passes, back-to-back ----
        for (int t = 0; t < 4; t++) begin
            x = 4'($urandom_range(0, 15)); wh = rnd8(); wo = rnd8();
            model(x, wh, wo, ehv, efin);
            do_start(x, wh, wo);
            wait_done(lat);
            chk("rnd_latency", 64'(lat), 64'(LAT));
            chk("rnd_hidden",  64'(hidden_val_o), 64'(ehv));
            chk("rnd_final",   64'(final_o), 64'(efin));
            ack();
        end
        ehv1 = ehv;
        x = 4'($urandom_range(0, 15)); wh = rnd8(); wo = rnd8();
        model(x, wh, wo, ehv, efin);
        do_start(x, wh, wo);
        chk("b2b_hold_start", 64'(hidden_val_o), 64'(ehv1));
        tick(); tick();
        emix = ehv1;
        emix[19:0] = ehv[19:0];
        chk("b2b_partial", 64'(hidden_val_o), 64'(emix));
        wait_done(lat);
        chk("b2b_latency", 64'(lat), 64'(LAT - 2));
        chk("b2b_final",   64'(final_o), 64'(efin));
        ack();

        // ---- async reset mid-OUTPUT ----
        do_start(4'd7, rnd8(), rnd8());
        for (int k = 0; k < NH + 2; k++) tick();
        chk("pre_rst_busy", 64'(busy_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_outputs", 64'({hidden_val_o, final_o, busy_o, done_o, b_pass_o}), 0);
        tick();
        rst_i = 1'b1;
        count_done(15, cnt);
        chk("arst_no_done", 64'({cnt[7:0], busy_o}), 0);

        // ---- clear mid-HIDDEN ----
        do_start(4'd5, fill8(8'd20), fill8(8'd3));
        wait_done(lat);
        chk("pre_clr_final", 64'(final_o), 64'(NH * 100 * 3));
        ack();
        do_start(4'd9, rnd8(), rnd8());
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_outputs", 64'({hidden_val_o, final_o, busy_o, done_o, b_pass_o}), 0);
        count_done(15, cnt);
        chk("clr_no_done", 64'({cnt[7:0], busy_o}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_forward_pass
`default_nettype wire
